fetch_unit: RTL and testbench

- Instruction fetch stage; producer side of the decode stage's instruction/pc/flush/stall interface.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {instruction, pc, valid} to decode.
- Honours stall (hold) and flush (redirect, discard in-flight fetches).

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word requests, buffers in-order responses for decode.
// Optional FETCH_MISALIGN_EN: a misaligned flush target parks the unit in MISALIGNED until the next flush.
module fetch_unit #(
  parameter int                    DATA_WIDTH        = 32,
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC          = '0,
  parameter int                    FIFO_DEPTH        = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [DATA_WIDTH-1:0]        flush_pc,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [DATA_WIDTH-1:0]        imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0]        pc,
  output logic                         valid
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                         misaligned
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN, MISALIGNED} state_t;

  state_t                 state, nstate;
  logic [DATA_WIDTH-1:0]  fetch_pc;
  logic [CW-1:0]          outstanding, drop_cnt, f_cnt, out_next;
  logic [AW-1:0]          f_wr, f_rd, q_wr, q_rd;
  logic                   mis_pend;

  logic [DATA_WIDTH-1:0]        f_pc  [FIFO_DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] f_ins [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]        q_pc  [FIFO_DEPTH];

  logic hs, rsp_ok, push, pop, credit, fifo_live, mis_flush;
  logic [DATA_WIDTH-1:0] flush_tgt;

`ifdef FETCH_MISALIGN_EN
  assign flush_tgt = flush_pc;
  assign mis_flush = |flush_pc[1:0];
`else
  logic unused_lsbs;
  assign unused_lsbs = ^flush_pc[1:0];
  assign flush_tgt   = {flush_pc[DATA_WIDTH-1:2], 2'b00};
  assign mis_flush   = 1'b0;
`endif

  // Responses with nothing outstanding are protocol errors and are ignored entirely.
  assign hs        = imem_req_valid && imem_req_ready;
  assign rsp_ok    = imem_rsp_valid && (outstanding != '0);
  assign push      = rsp_ok && (drop_cnt == '0) && !flush;
  assign fifo_live = (f_cnt != '0);
  assign pop       = fifo_live && !stall;
  assign out_next  = outstanding + CW'(hs) - CW'(rsp_ok);
  // Counting in-flight requests against buffered entries guarantees a FIFO slot for every response.
  assign credit    = ({1'b0, outstanding} + {1'b0, f_cnt}) < SW'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) state <= BOOT;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (flush) begin
      if (out_next != '0) nstate = DRAIN;
      else                nstate = mis_flush ? MISALIGNED : RUN;
    end else begin
      case (state)
        BOOT:    nstate = RUN;
        DRAIN:   if (drop_cnt == '0 || (drop_cnt == CW'(1) && rsp_ok))
                   nstate = mis_pend ? MISALIGNED : RUN;
        default: nstate = state;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = (state == RUN) && credit;
    imem_req_addr  = fetch_pc;
    valid          = fifo_live;
    instruction    = fifo_live ? f_ins[f_rd] : NOP;
    pc             = fifo_live ? f_pc[f_rd]  : '0;
    if (state == MISALIGNED) begin
      valid       = 1'b1;
      instruction = NOP;
      pc          = fetch_pc;
    end
`ifdef FETCH_MISALIGN_EN
    misaligned = (state == MISALIGNED);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      f_cnt       <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      mis_pend    <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (flush) begin
        // Everything still owed by memory after this edge belongs to the old stream.
        fetch_pc <= flush_tgt;
        drop_cnt <= out_next;
        f_cnt    <= '0;
        f_wr     <= '0;
        f_rd     <= '0;
        q_wr     <= '0;
        q_rd     <= '0;
        mis_pend <= mis_flush;
      end else begin
        if (hs) begin
          fetch_pc <= fetch_pc + DATA_WIDTH'(4);
          q_wr     <= q_wr + AW'(1);
        end
        if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          f_wr <= f_wr + AW'(1);
          q_rd <= q_rd + AW'(1);
        end
        if (pop) f_rd <= f_rd + AW'(1);
        f_cnt <= f_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && hs) q_pc[q_wr] <= fetch_pc;
    if (!reset && push) begin
      f_pc[f_wr]  <= q_pc[q_rd];
      f_ins[f_wr] <= imem_rsp_data;
    end
  end

`ifndef SYNTHESIS
  rsp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(imem_rsp_valid && outstanding == '0));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: in-bench memory model, stream-level expected-PC queue, decoupled monitor.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] instruction, pc;
  logic        valid;
`ifdef FETCH_MISALIGN_EN
  logic        misaligned;
`endif

  int tests = 0, fails = 0;

  fetch_unit #(.DATA_WIDTH(32), .INSTRUCTION_WIDTH(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instruction(instruction), .pc(pc), .valid(valid)
`ifdef FETCH_MISALIGN_EN
    , .misaligned(misaligned)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: live fetch stream as a PC queue, memory as an in-order latency queue.
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          dead = 0, buf_n = 0, lat = 1, cyc = 0;
  logic [31:0] next_pc = RPC, mis_pc = '0;
  logic        boot = 1'b1, mis_pend = 1'b0;
  logic        mis_now = 1'b0, exp_valid_now = 1'b0, chk_en = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a + 32'h0000_0093;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound(input string name, input int n, input int lim);
    tests++;
    if (n >= lim) begin
      fails++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, n, lim);
    end
  endtask

  task automatic reset_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; chk_en = 1'b0;
    end
    exp_q.delete(); mem_addr.delete(); mem_due.delete();
    dead = 0; buf_n = 0; mis_pend = 1'b0; next_pc = RPC; boot = 1'b1;
  endtask

  // One clock: drive inputs at the falling edge, then account for what the next rising edge does.
  task automatic step(input logic s, input logic f, input logic [31:0] fp, input int rdy_pct);
    logic hs, rsp, pop_m, live;
    @(negedge clk);
    cyc++;
    reset = 1'b0; stall = s; flush = f; flush_pc = fp;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    rsp = (mem_due.size() > 0) && (mem_due[0] <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word_of(mem_addr[0]) : $urandom();
    #1;
    mis_now       = mis_pend && dead == 0;
    exp_valid_now = (buf_n > 0) || mis_now;
    chk_en        = 1'b1;
    check("req_valid", {31'b0, imem_req_valid},
          {31'b0, !boot && dead == 0 && !mis_now && exp_q.size() < DEPTH});
    if (imem_req_valid) check("req_addr", imem_req_addr, next_pc);
    hs    = imem_req_valid && imem_req_ready;
    live  = rsp && !f && dead == 0;
    pop_m = (buf_n > 0) && !s && !f;
    if (rsp) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
      if (!f && dead > 0) dead--;
    end
    if (hs) begin
      mem_addr.push_back(imem_req_addr);
      mem_due.push_back(cyc + lat);
    end
    if (f) begin
      exp_q.delete();
      buf_n   = 0;
      dead    = mem_addr.size();
      next_pc = {fp[31:2], 2'b00};
`ifdef FETCH_MISALIGN_EN
      mis_pend = (fp[1:0] != 2'b00);
      mis_pc   = fp;
`endif
    end else begin
      if (hs) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
      buf_n = buf_n + (live ? 1 : 0) - (pop_m ? 1 : 0);
    end
    boot = 1'b0;
  endtask

  task automatic rand_step();
    logic [31:0] t;
    logic        f;
    if (cyc % 64 == 0 && mem_due.size() == 0) lat = $urandom_range(1, 4);
    f = ($urandom_range(99) < 3);
    t = $urandom() & 32'h0000_FFFC;
    case ($urandom_range(7))
      0:       t = 32'hFFFF_FFF4;
      1:       t[1:0] = 2'($urandom_range(1, 3));
      default: ;
    endcase
    step($urandom_range(99) < 25, f, t, 70);
  endtask

  // Monitor: compares the presented output against the head of the expected stream.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      check("valid", {31'b0, valid}, {31'b0, exp_valid_now});
`ifdef FETCH_MISALIGN_EN
      check("misaligned", {31'b0, misaligned}, {31'b0, mis_now});
`endif
      if (mis_now) begin
        check("mis_pc", pc, mis_pc);
        check("mis_instruction", instruction, NOP);
      end else if (!exp_valid_now) begin
        check("idle_instruction", instruction, NOP);
        check("idle_pc", pc, 32'h0);
      end else if (exp_q.size() > 0) begin
        check("pc", pc, exp_q[0]);
        check("instruction", instruction, word_of(exp_q[0]));
        if (!stall && !flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    reset_cycles(3);

    lat = 1;
    repeat (12) step(1'b0, 1'b0, 32'h0, 100);

    n = 0;
    while (buf_n == 0 && n < 20) begin step(1'b0, 1'b0, 32'h0, 100); n++; end
    bound("stall_setup", n, 20);
    repeat (5) step(1'b1, 1'b0, 32'h0, 100);
    repeat (8) step(1'b0, 1'b0, 32'h0, 100);

    lat = 3;
    n = 0;
    while (mem_addr.size() < 2 && n < 20) begin step(1'b0, 1'b0, 32'h0, 100); n++; end
    bound("inflight_setup", n, 20);
    step(1'b0, 1'b1, 32'h0000_0100, 100);
    repeat (16) step(1'b0, 1'b0, 32'h0, 100);

    lat = 2;
    n = 0;
    while (!(mem_due.size() > 0 && mem_due[0] <= cyc + 1) && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 100); n++;
    end
    bound("rsp_flush_setup", n, 20);
    step(1'b1, 1'b1, 32'h0000_0200, 100);
    repeat (10) step(1'b0, 1'b0, 32'h0, 100);

    lat = 1;
    n = 0;
    while (mem_due.size() > 0 && n < 20) begin step(1'b0, 1'b0, 32'h0, 0); n++; end
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 100);
    repeat (12) step(1'b0, 1'b0, 32'h0, 100);

    step(1'b0, 1'b1, 32'h0000_0102, 100);
    repeat (10) step(1'b0, 1'b0, 32'h0, 100);
    step(1'b0, 1'b1, 32'h0000_0040, 100);
    repeat (10) step(1'b0, 1'b0, 32'h0, 100);

    repeat (2500) rand_step();
    reset_cycles(2);
    repeat (200) rand_step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
